sd_lese_arbiter: RTL and testbench
==================================

SD_LESE_ARBITER -- requirements
Module: sd_lese_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd5000000, the SD-access cycle limit before abort.
REQ-002 SHALL have port Clock  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port Reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports A_Lesen / B_Lesen  input  1  read request, ports A / B.
REQ-005 SHALL have ports A_Adresse / B_Adresse  input  32  word address of the request.
REQ-006 SHALL have ports A_Daten / B_Daten  output  32  read data, held until that port's next response.
REQ-007 SHALL have ports A_Fertig / B_Fertig  output  1  one-cycle response pulse.
REQ-008 SHALL have port Cache_Loeschen  input  1  invalidate the word cache.
REQ-009 SHALL have port SD_Adresse  output  32  word address to the SD reader.
REQ-010 SHALL have port SD_Lesen  output  1  read strobe to the SD reader.
REQ-011 SHALL have port SD_Daten  input  32  data from the SD reader.
REQ-012 SHALL have ports SD_Fertig / SD_Busy  input  1  completion and busy from the SD reader.
REQ-013 SHALL have port Zeitueberschreitung  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement states IDLE, LOOKUP, ISSUE, WAIT_FERTIG, ANTWORT.
REQ-015 In IDLE, SHALL grant one pending request using round-robin:
- pointer initially favours A;
- after each grant, the pointer favours the other port;
- a lone requester is granted regardless of the pointer.
REQ-016 On grant, SHALL latch the port ID and address, then move to LOOKUP; later changes on X_Adresse SHALL be ignored.
REQ-017 In LOOKUP, hit = cache valid and tag equals the latched address:
- hit: move to ANTWORT with the cached data;
- miss: move to ISSUE.
REQ-018 Hit latency: grant in cycle N, LOOKUP in N+1, X_Fertig high in N+2.
REQ-019 In ISSUE, SHALL assert SD_Lesen only while SD_Busy=0 and SD_Fertig=0.
REQ-020 In ISSUE, on the first cycle SD_Busy=1 is seen, SHALL drop SD_Lesen and move to WAIT_FERTIG.
REQ-021 SD_Adresse SHALL equal the latched address from ISSUE entry until WAIT_FERTIG exits.
REQ-022 In WAIT_FERTIG, on SD_Fertig=1, SHALL:
- capture SD_Daten;
- load the cache (tag = address, valid = 1);
- move to ANTWORT.
REQ-023 In ANTWORT, for exactly one cycle, SHALL:
- drive the granted port's X_Daten with the result and X_Fertig high;
- keep the other port's outputs unchanged;
- return to IDLE.
REQ-024 SHALL issue SD_Lesen at most once per miss, and never while SD_Busy=1 or SD_Fertig=1.
REQ-025 A requester holding X_Lesen high in its X_Fertig cycle SHALL be treated as a new request from the following IDLE cycle.
REQ-026 Cache hits SHALL be served while the SD reader is still busy draining a sector.
REQ-027 A 24-bit timeout counter SHALL:
- clear on ISSUE entry;
- increment each cycle in ISSUE or WAIT_FERTIG;
- on reaching TIMEOUT, go to ANTWORT with data 32'hFFFFFFFF, set Zeitueberschreitung, skip the cache fill, and drop SD_Lesen.
REQ-028 After a timeout, a late SD_Fertig SHALL be ignored; the next ISSUE waits for SD_Busy=0 and SD_Fertig=0.
REQ-029 Cache_Loeschen SHALL clear the valid bit next cycle; if it coincides with a cache fill, invalidation SHALL win.
REQ-030 A request arriving in a non-IDLE state SHALL wait; requests are never dropped while X_Lesen stays high.

Reset
REQ-031 On Reset, SHALL:
- enter IDLE;
- clear A_Daten, B_Daten, A_Fertig, B_Fertig, SD_Lesen and SD_Adresse to 0;
- clear cache valid, the timeout counter and Zeitueberschreitung;
- set the round-robin pointer to favour A.
REQ-032 Reset mid-transaction SHALL abandon it with no X_Fertig pulse; the SD reader is reset by the same Reset.
REQ-033 While SD_Busy=1 after reset (SD card init), a miss SHALL wait in ISSUE; the timeout counter runs.

Verification
REQ-034 The bench SHALL cover the following scenarios:
- A_Lesen with address 0x40 on a miss, SD model returns 0xDEADBEEF after 50 cycles -> one SD_Lesen pulse with SD_Adresse=0x40; A_Fertig one cycle with A_Daten=0xDEADBEEF; B outputs unchanged.
- A then B, both at 0x40 back-to-back -> B served from cache: B_Fertig 2 cycles after grant; no second SD_Lesen; B_Daten=0xDEADBEEF.
- A and B asserted together, each with a distinct miss, repeated 4 times -> grants alternate A,B,A,B; each SD_Lesen issued only when SD_Busy=0 and SD_Fertig=0.
- Cache_Loeschen pulsed in the same cycle SD_Fertig fills 0x80; then A reads 0x80 -> second SD_Lesen issued (miss).
- SD model never asserts SD_Fertig, TIMEOUT=100 -> X_Fertig at cycle 100 after ISSUE with data 0xFFFFFFFF; Zeitueberschreitung=1 until Reset.
- Reset asserted during WAIT_FERTIG -> no X_Fertig pulse; all outputs 0 next cycle; the following read of 0x40 is a miss.

Source files
------------

// File: rtl/sd_lese_arbiter_if.sv
// Request/response bundle between the two read ports, the word cache arbiter
// and the SD reader. The slave modport is the arbiter's view.
interface sd_lese_arbiter_if;
  logic        A_Lesen, B_Lesen;
  logic [31:0] A_Adresse, B_Adresse;
  logic [31:0] A_Daten, B_Daten;
  logic        A_Fertig, B_Fertig;
  logic        Cache_Loeschen;
  logic [31:0] SD_Adresse;
  logic        SD_Lesen;
  logic [31:0] SD_Daten;
  logic        SD_Fertig, SD_Busy;
  logic        Zeitueberschreitung;

  modport slave (
    input  A_Lesen, B_Lesen, A_Adresse, B_Adresse, Cache_Loeschen,
           SD_Daten, SD_Fertig, SD_Busy,
    output A_Daten, B_Daten, A_Fertig, B_Fertig, SD_Adresse, SD_Lesen,
           Zeitueberschreitung
  );

  modport master (
    output A_Lesen, B_Lesen, A_Adresse, B_Adresse, Cache_Loeschen,
           SD_Daten, SD_Fertig, SD_Busy,
    input  A_Daten, B_Daten, A_Fertig, B_Fertig, SD_Adresse, SD_Lesen,
           Zeitueberschreitung
  );
endinterface

// File: rtl/sd_lese_arbiter.sv
// Round-robin arbiter for two read ports in front of one SD reader, with a
// single-word cache and an SD access timeout.
module sd_lese_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd5000000
) (
  input logic           Clock,
  input logic           Reset,
  sd_lese_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, ISSUE, WAIT_FERTIG, ANTWORT} state_t;

  state_t      state_q;
  logic        gnt_b_q, prio_b_q;
  logic [31:0] adr_q, sd_adr_q, a_daten_q, b_daten_q;
  logic        a_fertig_q, b_fertig_q, tmo_flag_q;
  logic        valid_q;
  logic [31:0] tag_q, line_q;
  logic [23:0] cnt_q, cnt_d;

  logic        pick_b, hit, tmo, fill, abort, fin;
  logic [31:0] fin_data;

  assign pick_b = bus.B_Lesen && (!bus.A_Lesen || prio_b_q);
  assign hit    = valid_q && (tag_q == adr_q);
  assign cnt_d  = cnt_q + 24'd1;
  assign tmo    = (cnt_d == TIMEOUT);
  assign fill   = (state_q == WAIT_FERTIG) && bus.SD_Fertig;
  assign abort  = ((state_q == ISSUE) || (state_q == WAIT_FERTIG)) && tmo && !fill;

  // The strobe is gated live by the reader status so it can never overlap Busy/Fertig.
  assign bus.SD_Lesen            = (state_q == ISSUE) && !bus.SD_Busy && !bus.SD_Fertig && !tmo;
  assign bus.SD_Adresse          = sd_adr_q;
  assign bus.A_Daten             = a_daten_q;
  assign bus.B_Daten             = b_daten_q;
  assign bus.A_Fertig            = a_fertig_q;
  assign bus.B_Fertig            = b_fertig_q;
  assign bus.Zeitueberschreitung = tmo_flag_q;

  always_comb begin
    fin      = 1'b0;
    fin_data = 32'hFFFF_FFFF;
    unique case (state_q)
      LOOKUP:      begin fin = hit; fin_data = line_q; end
      ISSUE:       fin = tmo;
      WAIT_FERTIG: begin
        fin = fill || tmo;
        if (fill) fin_data = bus.SD_Daten;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      gnt_b_q    <= 1'b0;
      prio_b_q   <= 1'b0;
      adr_q      <= '0;
      sd_adr_q   <= '0;
      a_daten_q  <= '0;
      b_daten_q  <= '0;
      a_fertig_q <= 1'b0;
      b_fertig_q <= 1'b0;
      tmo_flag_q <= 1'b0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
    end else begin
      a_fertig_q <= 1'b0;
      b_fertig_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.A_Lesen || bus.B_Lesen) begin
          gnt_b_q  <= pick_b;
          prio_b_q <= !pick_b;
          adr_q    <= pick_b ? bus.B_Adresse : bus.A_Adresse;
          state_q  <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          state_q <= ANTWORT;
        end else begin
          cnt_q    <= '0;
          sd_adr_q <= adr_q;
          state_q  <= ISSUE;
        end
        ISSUE: begin
          cnt_q <= cnt_d;
          if (tmo)              state_q <= ANTWORT;
          else if (bus.SD_Busy) state_q <= WAIT_FERTIG;
        end
        WAIT_FERTIG: begin
          cnt_q <= cnt_d;
          if (fin) state_q <= ANTWORT;
        end
        ANTWORT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Only the granted port's result registers move; the other port holds.
      if (fin) begin
        if (gnt_b_q) begin b_daten_q <= fin_data; b_fertig_q <= 1'b1; end
        else         begin a_daten_q <= fin_data; a_fertig_q <= 1'b1; end
      end
      if (abort) tmo_flag_q <= 1'b1;
      if (fill) begin
        valid_q <= 1'b1;
        tag_q   <= adr_q;
        line_q  <= bus.SD_Daten;
      end
      if (bus.Cache_Loeschen) valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_lese_arbiter.sv
// Directed bench for sd_lese_arbiter with a behavioural SD reader that answers
// after sd_lat cycles, or never when sd_hang is set.
module tb_sd_lese_arbiter;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  sd_lese_arbiter_if bus();

  sd_lese_arbiter #(.TIMEOUT(24'd100)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  always #5 Clock = ~Clock;

  int n_checks = 0, n_fail = 0;
  int lesen_cnt = 0, proto_err = 0, sd_lat = 50, sd_left = 0;
  bit sd_hang = 0, clr_on_fill = 0, lesen_prev = 0;
  logic [31:0] sd_adr_seen = '0, sd_req = '0;

  function automatic logic [31:0] sd_data(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (32'hA500_0000 ^ a);
  endfunction

  // SD reader model: samples the strobe at the falling edge, then updates.
  always @(negedge Clock) begin
    if (Reset) begin
      bus.SD_Busy = 0; bus.SD_Fertig = 0; bus.SD_Daten = '0;
      bus.Cache_Loeschen = 0; sd_left = 0; lesen_prev = 0;
    end else begin
      if (bus.SD_Lesen && (bus.SD_Busy || bus.SD_Fertig)) proto_err++;
      if (bus.SD_Lesen && !lesen_prev) begin lesen_cnt++; sd_adr_seen = bus.SD_Adresse; end
      lesen_prev = bus.SD_Lesen;
      bus.SD_Fertig = 0;
      bus.Cache_Loeschen = 0;
      if (!bus.SD_Busy && bus.SD_Lesen) begin
        bus.SD_Busy = 1; sd_left = sd_lat; sd_req = bus.SD_Adresse;
      end else if (bus.SD_Busy && !sd_hang) begin
        sd_left--;
        if (sd_left == 0) begin
          bus.SD_Busy = 0; bus.SD_Fertig = 1; bus.SD_Daten = sd_data(sd_req);
          bus.Cache_Loeschen = clr_on_fill;
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on one port, started while the DUT is idle; returns data and
  // cycles from request to Fertig. The address is scrambled after the grant.
  task automatic serve(input bit pb, input logic [31:0] adr,
                       output logic [31:0] dat, output int lat);
    bit done = 0, stray = 0;
    dat = 'x; lat = -1;
    if (pb) begin bus.B_Lesen = 1; bus.B_Adresse = adr; end
    else    begin bus.A_Lesen = 1; bus.A_Adresse = adr; end
    for (int i = 1; i <= 300 && !done; i++) begin
      step();
      if (i == 1) begin bus.A_Adresse = ~adr; bus.B_Adresse = ~adr; end
      if (pb ? bus.A_Fertig : bus.B_Fertig) stray = 1;
      if (pb ? bus.B_Fertig : bus.A_Fertig) begin
        done = 1; lat = i; dat = pb ? bus.B_Daten : bus.A_Daten;
        bus.A_Lesen = 0; bus.B_Lesen = 0;
      end
    end
    bus.A_Lesen = 0; bus.B_Lesen = 0;
    check("serve_done", 32'(done), 32'd1);
    check("other_port_quiet", 32'(stray), 32'd0);
    step();
  endtask

  task automatic both(input logic [31:0] aa, input logic [31:0] ba, output bit first_b,
                      output logic [31:0] ad, output logic [31:0] bd);
    bit a_done = 0, b_done = 0;
    first_b = 0; ad = 'x; bd = 'x;
    bus.A_Lesen = 1; bus.A_Adresse = aa;
    bus.B_Lesen = 1; bus.B_Adresse = ba;
    for (int i = 0; i < 400 && !(a_done && b_done); i++) begin
      step();
      if (bus.A_Fertig) begin a_done = 1; ad = bus.A_Daten; bus.A_Lesen = 0; end
      if (bus.B_Fertig) begin
        if (!a_done) first_b = 1;
        b_done = 1; bd = bus.B_Daten; bus.B_Lesen = 0;
      end
    end
    bus.A_Lesen = 0; bus.B_Lesen = 0;
    check("both_done", 32'(a_done && b_done), 32'd1);
    step();
  endtask

  initial begin
    logic [31:0] d, ad, bd;
    int lat, c0;
    bit fb, seen;
    bus.A_Lesen = 0; bus.B_Lesen = 0; bus.A_Adresse = '0; bus.B_Adresse = '0;

    step(); step();
    check("rst_a_daten", bus.A_Daten, 32'h0);
    check("rst_b_daten", bus.B_Daten, 32'h0);
    check("rst_a_fertig", 32'(bus.A_Fertig), 32'h0);
    check("rst_b_fertig", 32'(bus.B_Fertig), 32'h0);
    check("rst_sd_lesen", 32'(bus.SD_Lesen), 32'h0);
    check("rst_sd_adresse", bus.SD_Adresse, 32'h0);
    check("rst_timeout", 32'(bus.Zeitueberschreitung), 32'h0);
    Reset = 0;
    step();

    // Miss on 0x40 served by the SD reader
    c0 = lesen_cnt;
    serve(0, 32'h40, d, lat);
    check("s1_data", d, 32'hDEAD_BEEF);
    check("s1_latency", lat, 53);
    check("s1_sd_reads", lesen_cnt - c0, 1);
    check("s1_sd_addr", sd_adr_seen, 32'h40);
    check("s1_b_daten_held", bus.B_Daten, 32'h0);

    // B hits the word A just filled
    serve(1, 32'h40, d, lat);
    check("s2_data", d, 32'hDEAD_BEEF);
    check("s2_hit_latency", lat, 2);
    check("s2_sd_reads", lesen_cnt - c0, 1);
    check("s2_a_daten_held", bus.A_Daten, 32'hDEAD_BEEF);

    // Simultaneous distinct misses: A wins each round, then B
    for (int r = 0; r < 4; r++) begin
      c0 = lesen_cnt;
      both(32'h100 + 32'(16 * r), 32'h104 + 32'(16 * r), fb, ad, bd);
      check("s3_a_first", 32'(fb), 32'd0);
      check("s3_a_data", ad, sd_data(32'h100 + 32'(16 * r)));
      check("s3_b_data", bd, sd_data(32'h104 + 32'(16 * r)));
      check("s3_sd_reads", lesen_cnt - c0, 2);
    end
    // A lone grant to A hands priority to B for the next contest
    serve(0, 32'h134, d, lat);
    check("s3_lone_hit_latency", lat, 2);
    both(32'h200, 32'h204, fb, ad, bd);
    check("s3_b_first", 32'(fb), 32'd1);
    check("s3_protocol", proto_err, 0);

    // Invalidate coinciding with the fill of 0x80
    c0 = lesen_cnt;
    clr_on_fill = 1;
    serve(0, 32'h80, d, lat);
    clr_on_fill = 0;
    check("s4_fill_data", d, sd_data(32'h80));
    serve(0, 32'h80, d, lat);
    check("s4_refetch_data", d, sd_data(32'h80));
    check("s4_sd_reads", lesen_cnt - c0, 2);
    serve(0, 32'h80, d, lat);
    check("s4_then_hit", lat, 2);
    check("s4_sd_reads_hit", lesen_cnt - c0, 2);

    // SD reader never answers: timeout after 100 cycles in ISSUE/WAIT
    sd_hang = 1;
    c0 = lesen_cnt;
    serve(0, 32'h300, d, lat);
    check("s5_latency", lat, 102);
    check("s5_data", d, 32'hFFFF_FFFF);
    check("s5_flag", 32'(bus.Zeitueberschreitung), 32'd1);
    check("s5_sd_reads", lesen_cnt - c0, 1);
    serve(1, 32'h80, d, lat);
    check("s5_hit_while_busy_lat", lat, 2);
    check("s5_hit_while_busy_data", d, sd_data(32'h80));
    repeat (20) step();
    check("s5_flag_sticky", 32'(bus.Zeitueberschreitung), 32'd1);

    Reset = 1; step(); Reset = 0; sd_hang = 0;
    check("s6_flag_cleared", 32'(bus.Zeitueberschreitung), 32'd0);
    check("s6_a_daten_cleared", bus.A_Daten, 32'h0);
    step();

    // Reset in the middle of an SD wait
    seen = 0;
    bus.A_Lesen = 1; bus.A_Adresse = 32'h40;
    repeat (10) begin step(); if (bus.A_Fertig || bus.B_Fertig) seen = 1; end
    check("s6_sd_started", 32'(bus.SD_Busy), 32'd1);
    Reset = 1; bus.A_Lesen = 0;
    step();
    check("s6_rst_a_fertig", 32'(bus.A_Fertig), 32'd0);
    check("s6_rst_sd_lesen", 32'(bus.SD_Lesen), 32'd0);
    check("s6_rst_sd_adresse", bus.SD_Adresse, 32'h0);
    check("s6_rst_a_daten", bus.A_Daten, 32'h0);
    Reset = 0;
    repeat (5) begin step(); if (bus.A_Fertig || bus.B_Fertig) seen = 1; end
    check("s6_no_fertig", 32'(seen), 32'd0);
    c0 = lesen_cnt;
    serve(0, 32'h40, d, lat);
    check("s6_miss_after_reset", lesen_cnt - c0, 1);
    check("s6_data", d, 32'hDEAD_BEEF);
    check("s6_protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
